// File: rtl/led_bank_driver.sv
// led_bank_driver
//   Memory-mapped LED bank driver with per-LED blink mask, global PWM
//   brightness, enable/resync control and register readback.
//   It sits behind MemOrIO on the LED chip-select. The CPU accesses the
//   LED state one 16-bit halfword at a time.
//
// Register map (NDR = ceil(LED_W/16)):
//   k          DATA_k  data[16k+15:16k]
//   NDR+k      MASK_k  blink mask[16k+15:16k]
//   2*NDR      DUTY    bits[PWM_BITS-1:0]
//   2*NDR+1    CTRL    bit0 EN, bit1 RESYNC (write-only, self-clearing)
//
// Ports:
//   led_clk   in   1       system clock, all state on posedge
//   ledrst    in   1       synchronous active-high reset
//   ledcs     in   1       chip select
//   ledwrite  in   1       1 = write cycle, 0 = read cycle
//   ledaddr   in   ADDR_W  register index
//   ledwdata  in   16      write data
//   ledrdata  out  16      read data (combinational)
//   ledout    out  LED_W   registered LED drive
module led_bank_driver #(
  parameter int unsigned LED_W     = 24,
  parameter int unsigned ADDR_W    = 3,
  parameter int unsigned PWM_BITS  = 4,
  parameter int unsigned BLINK_DIV = 25_000_000
) (
  input  logic              led_clk,
  input  logic              ledrst,
  input  logic              ledcs,
  input  logic              ledwrite,
  input  logic [ADDR_W-1:0] ledaddr,
  input  logic [15:0]       ledwdata,
  output logic [15:0]       ledrdata,
  output logic [LED_W-1:0]  ledout
);

  localparam int unsigned NDR      = (LED_W + 15) / 16;
  localparam int unsigned PADW     = NDR * 16;
  localparam int unsigned IDX_DUTY = 2 * NDR;
  localparam int unsigned IDX_CTRL = 2 * NDR + 1;
  localparam int unsigned BCNT_W   = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  // Architectural state
  logic [LED_W-1:0]    r_data;
  logic [LED_W-1:0]    r_mask;
  logic [PWM_BITS-1:0] r_duty;
  logic                r_en;
  logic [BCNT_W-1:0]   r_bcnt;
  logic                r_phase;
  logic [PWM_BITS-1:0] r_pcnt;
  logic [LED_W-1:0]    r_ledout;

  // Decoded access strobes
  logic              w_wr;
  logic              w_rd;
  logic [NDR-1:0]    w_data_wr;
  logic [NDR-1:0]    w_mask_wr;
  logic [NDR-1:0]    w_data_rd;
  logic [NDR-1:0]    w_mask_rd;
  logic              w_duty_wr;
  logic              w_ctrl_wr;
  logic              w_resync;
  logic              w_bwrap;
  logic              w_pwm_on;
  logic [LED_W-1:0]  w_data_nxt;
  logic [LED_W-1:0]  w_mask_nxt;
  logic [LED_W-1:0]  w_led_nxt;
  logic [PADW-1:0]   w_data_pad;
  logic [PADW-1:0]   w_mask_pad;
  logic [15:0]       w_rd_acc [NDR+1];

  assign w_wr = ledcs & ledwrite;
  assign w_rd = ledcs & ~ledwrite;

  assign w_duty_wr = w_wr & (ledaddr == ADDR_W'(IDX_DUTY));
  assign w_ctrl_wr = w_wr & (ledaddr == ADDR_W'(IDX_CTRL));
  assign w_resync  = w_ctrl_wr & ledwdata[1];

  // Per-halfword address decode for DATA/MASK lanes
  for (genvar k = 0; k < NDR; k++) begin : g_lane_dec
    assign w_data_wr[k] = w_wr & (ledaddr == ADDR_W'(k));
    assign w_mask_wr[k] = w_wr & (ledaddr == ADDR_W'(NDR + k));
    assign w_data_rd[k] = w_rd & (ledaddr == ADDR_W'(k));
    assign w_mask_rd[k] = w_rd & (ledaddr == ADDR_W'(NDR + k));
  end

  // Next DATA/MASK per bit; bits beyond LED_W simply have no storage
  for (genvar i = 0; i < LED_W; i++) begin : g_bit_wr
    assign w_data_nxt[i] = w_data_wr[i/16] ? ledwdata[i%16] : r_data[i];
    assign w_mask_nxt[i] = w_mask_wr[i/16] ? ledwdata[i%16] : r_mask[i];
  end

  // Zero-padded views so the top halfword reads back 0 above LED_W
  assign w_data_pad = PADW'(r_data);
  assign w_mask_pad = PADW'(r_mask);

  // Read mux built as an OR chain across the one-hot lane selects
  assign w_rd_acc[0] = 16'h0000;
  for (genvar k = 0; k < NDR; k++) begin : g_lane_rd
    assign w_rd_acc[k+1] = w_rd_acc[k]
                         | ({16{w_data_rd[k]}} & w_data_pad[16*k +: 16])
                         | ({16{w_mask_rd[k]}} & w_mask_pad[16*k +: 16]);
  end

  always_comb begin
    ledrdata = w_rd_acc[NDR];
    if (w_rd && (ledaddr == ADDR_W'(IDX_DUTY))) begin
      ledrdata = 16'(r_duty);
    end
    if (w_rd && (ledaddr == ADDR_W'(IDX_CTRL))) begin
      ledrdata = {15'b0, r_en};
    end
  end

  // Register file
  always_ff @(posedge led_clk) begin
    if (ledrst) begin
      r_data <= '0;
      r_mask <= '0;
      r_duty <= '1;
      r_en   <= 1'b1;
    end else begin
      r_data <= w_data_nxt;
      r_mask <= w_mask_nxt;
      if (w_duty_wr) begin
        r_duty <= ledwdata[PWM_BITS-1:0];
      end
      if (w_ctrl_wr) begin
        r_en <= ledwdata[0];
      end
    end
  end

  // Blink timebase; resync overrides a coincident wrap toggle
  assign w_bwrap = (r_bcnt == BCNT_W'(BLINK_DIV - 1));

  always_ff @(posedge led_clk) begin
    if (ledrst) begin
      r_bcnt  <= '0;
      r_phase <= 1'b0;
    end else if (w_resync) begin
      r_bcnt  <= '0;
      r_phase <= 1'b0;
    end else if (w_bwrap) begin
      r_bcnt  <= '0;
      r_phase <= ~r_phase;
    end else begin
      r_bcnt  <= r_bcnt + BCNT_W'(1);
    end
  end

  // Free-running PWM counter; all-ones duty means fully on
  assign w_pwm_on = (&r_duty) | (r_pcnt < r_duty);

  always_ff @(posedge led_clk) begin
    if (ledrst) begin
      r_pcnt <= '0;
    end else begin
      r_pcnt <= r_pcnt + PWM_BITS'(1);
    end
  end

  // Output stage: masked LEDs follow the blink phase
  assign w_led_nxt = {LED_W{r_en & w_pwm_on}} & r_data & (~r_mask | {LED_W{r_phase}});

  always_ff @(posedge led_clk) begin
    if (ledrst) begin
      r_ledout <= '0;
    end else begin
      r_ledout <= w_led_nxt;
    end
  end

  assign ledout = r_ledout;

endmodule

// File: tb/tb_led_bank_driver.sv
// Directed testbench for led_bank_driver (LED_W=24, BLINK_DIV=4, PWM_BITS=4).
module tb_led_bank_driver;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs;
  logic        we;
  logic [2:0]  addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic [23:0] ledout;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  led_bank_driver #(
    .LED_W(24), .ADDR_W(3), .PWM_BITS(4), .BLINK_DIV(4)
  ) dut (
    .led_clk (clk),
    .ledrst  (rst),
    .ledcs   (cs),
    .ledwrite(we),
    .ledaddr (addr),
    .ledwdata(wdata),
    .ledrdata(rdata),
    .ledout  (ledout)
  );

  typedef struct {
    logic        cs;
    logic        we;
    logic [2:0]  addr;
    logic [15:0] wdata;
    logic [15:0] exp_rd;
    logic        chk_led;
    logic [23:0] exp_led;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic c, input logic w, input logic [2:0] a,
                              input logic [15:0] d, input logic [15:0] er,
                              input logic cl, input logic [23:0] el);
    vec_t v;
    v.cs = c; v.we = w; v.addr = a; v.wdata = d;
    v.exp_rd = er; v.chk_led = cl; v.exp_led = el;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    cs = 1'b1; we = 1'b1; addr = a; wdata = d;
    tick();
    cs = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [15:0] e, input string nm);
    cs = 1'b1; we = 1'b0; addr = a;
    #1;
    check(nm, 32'(rdata), 32'(e));
    cs = 1'b0;
  endtask

  task automatic pwm_run(input logic [3:0] duty, input int exp_on, input string nm);
    int on_cnt;
    on_cnt = 0;
    wr(3'd4, 16'(duty));
    tick();
    for (int c = 0; c < 16; c++) begin
      tick();
      if (ledout == 24'h00FFFF) on_cnt++;
      else check({nm, "_level"}, 32'(ledout), 32'h0);
    end
    check({nm, "_on_count"}, 32'(on_cnt), 32'(exp_on));
  endtask

  initial begin
    rst = 1'b1; cs = 1'b0; we = 1'b0; addr = '0; wdata = '0;
    repeat (2) tick();
    rst = 1'b0;
    check("reset_ledout", 32'(ledout), 32'h0);
    check("idle_rdata", 32'(rdata), 32'h0);
    rd(3'd4, 16'h000F, "reset_duty");
    rd(3'd5, 16'h0001, "reset_ctrl");
    rd(3'd0, 16'h0000, "reset_data0");

    //            cs    we    addr  wdata     exp_rd    chk   exp_led
    vecs.push_back(mk(1'b1, 1'b1, 3'd0, 16'hA5A5, 16'h0000, 1'b1, 24'h000000));
    vecs.push_back(mk(1'b1, 1'b1, 3'd1, 16'h00C3, 16'h0000, 1'b1, 24'h00A5A5));
    vecs.push_back(mk(1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b1, 24'hC3A5A5));
    vecs.push_back(mk(1'b1, 1'b0, 3'd0, 16'h0000, 16'hA5A5, 1'b1, 24'hC3A5A5));
    vecs.push_back(mk(1'b1, 1'b0, 3'd1, 16'h0000, 16'h00C3, 1'b1, 24'hC3A5A5));
    vecs.push_back(mk(1'b1, 1'b1, 3'd1, 16'hFFFF, 16'h0000, 1'b1, 24'hC3A5A5));
    vecs.push_back(mk(1'b1, 1'b0, 3'd1, 16'h0000, 16'h00FF, 1'b1, 24'hFFA5A5));
    vecs.push_back(mk(1'b1, 1'b0, 3'd7, 16'h0000, 16'h0000, 1'b1, 24'hFFA5A5));
    vecs.push_back(mk(1'b1, 1'b0, 3'd6, 16'h0000, 16'h0000, 1'b1, 24'hFFA5A5));
    vecs.push_back(mk(1'b1, 1'b0, 3'd5, 16'h0000, 16'h0001, 1'b1, 24'hFFA5A5));
    vecs.push_back(mk(1'b1, 1'b0, 3'd4, 16'h0000, 16'h000F, 1'b1, 24'hFFA5A5));
    vecs.push_back(mk(1'b1, 1'b0, 3'd2, 16'h0000, 16'h0000, 1'b1, 24'hFFA5A5));
    vecs.push_back(mk(1'b1, 1'b0, 3'd3, 16'h0000, 16'h0000, 1'b1, 24'hFFA5A5));
    vecs.push_back(mk(1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b1, 24'hFFA5A5));
    vecs.push_back(mk(1'b0, 1'b1, 3'd0, 16'h1234, 16'h0000, 1'b1, 24'hFFA5A5));
    vecs.push_back(mk(1'b1, 1'b0, 3'd0, 16'h0000, 16'hA5A5, 1'b1, 24'hFFA5A5));
    vecs.push_back(mk(1'b1, 1'b1, 3'd5, 16'h0000, 16'h0000, 1'b1, 24'hFFA5A5));
    vecs.push_back(mk(1'b1, 1'b0, 3'd0, 16'h0000, 16'hA5A5, 1'b1, 24'h000000));
    vecs.push_back(mk(1'b1, 1'b0, 3'd5, 16'h0000, 16'h0000, 1'b1, 24'h000000));
    vecs.push_back(mk(1'b1, 1'b0, 3'd1, 16'h0000, 16'h00FF, 1'b1, 24'h000000));
    vecs.push_back(mk(1'b1, 1'b1, 3'd5, 16'h0001, 16'h0000, 1'b1, 24'h000000));
    vecs.push_back(mk(1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b1, 24'hFFA5A5));
    vecs.push_back(mk(1'b1, 1'b1, 3'd3, 16'hFFFF, 16'h0000, 1'b1, 24'hFFA5A5));
    vecs.push_back(mk(1'b1, 1'b0, 3'd3, 16'h0000, 16'h00FF, 1'b0, 24'h000000));
    vecs.push_back(mk(1'b1, 1'b1, 3'd3, 16'h0000, 16'h0000, 1'b0, 24'h000000));
    vecs.push_back(mk(1'b1, 1'b0, 3'd3, 16'h0000, 16'h0000, 1'b1, 24'hFFA5A5));
    vecs.push_back(mk(1'b0, 1'b0, 3'd0, 16'h0000, 16'h0000, 1'b1, 24'hFFA5A5));
    vecs.push_back(mk(1'b1, 1'b1, 3'd7, 16'hFFFF, 16'h0000, 1'b1, 24'hFFA5A5));
    vecs.push_back(mk(1'b1, 1'b0, 3'd0, 16'h0000, 16'hA5A5, 1'b1, 24'hFFA5A5));

    for (int j = 0; j < vecs.size(); j++) begin
      cs = vecs[j].cs; we = vecs[j].we; addr = vecs[j].addr; wdata = vecs[j].wdata;
      #1;
      check($sformatf("vec%0d_rdata", j), 32'(rdata), 32'(vecs[j].exp_rd));
      tick();
      if (vecs[j].chk_led) check($sformatf("vec%0d_ledout", j), 32'(ledout), 32'(vecs[j].exp_led));
    end
    cs = 1'b0; we = 1'b0;

    // Blink with resync: 4 cycles off, 4 on, repeating
    wr(3'd1, 16'h0000);
    wr(3'd0, 16'h0001);
    wr(3'd2, 16'h0001);
    wr(3'd5, 16'h0003);
    rd(3'd5, 16'h0001, "ctrl_resync_not_readable");
    for (int k = 1; k <= 16; k++) begin
      tick();
      check($sformatf("blink_c%0d", k), 32'(ledout), (((k - 1) / 4) % 2 == 1) ? 32'h1 : 32'h0);
    end

    // PWM brightness
    wr(3'd2, 16'h0000);
    wr(3'd0, 16'hFFFF);
    pwm_run(4'h4, 4, "pwm_duty4");
    rd(3'd4, 16'h0004, "duty_readback");
    pwm_run(4'h0, 0, "pwm_duty0");
    pwm_run(4'hE, 14, "pwm_duty14");
    pwm_run(4'hF, 16, "pwm_duty15");

    // Reset wins over a concurrent write
    wr(3'd4, 16'h0003);
    wr(3'd5, 16'h0000);
    rst = 1'b1; cs = 1'b1; we = 1'b1; addr = 3'd0; wdata = 16'hFFFF;
    tick();
    rst = 1'b0; cs = 1'b0; we = 1'b0;
    check("rst_ledout", 32'(ledout), 32'h0);
    rd(3'd0, 16'h0000, "rst_data0");
    rd(3'd1, 16'h0000, "rst_data1");
    rd(3'd2, 16'h0000, "rst_mask0");
    rd(3'd4, 16'h000F, "rst_duty");
    rd(3'd5, 16'h0001, "rst_ctrl");

    // Blink counter restarts from reset: edges R+3..R+10 give 0,0,1,1,1,1,0,0
    wr(3'd0, 16'h0001);
    wr(3'd2, 16'h0001);
    for (int k = 3; k <= 10; k++) begin
      tick();
      check($sformatf("rst_blink_e%0d", k), 32'(ledout), (k >= 5 && k <= 8) ? 32'h1 : 32'h0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
